// File: rtl/rect_draw_pkg.sv
// rtl/rect_draw_pkg.sv - shared types and field widths for the rectangle draw arbiter
// Purpose: FSM state encoding, default screen size and descriptor field widths.
// Optional feature macro used by the top: RECT_DRAW_ARBITER_CLIP_EN.
package rect_draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam int X_W   = 8;  // pixel x width
    localparam int Y_W   = 7;  // pixel y width
    localparam int SZ_W  = 4;  // width-1 / height-1 field and scan counters
    localparam int COL_W = 3;  // colour width

endpackage

// File: rtl/rect_draw_arbiter_rr_picker.sv
// rtl/rect_draw_arbiter_rr_picker.sv - round-robin priority picker
// Purpose: combinational round-robin selection; search begins one past the last winner.
// Ports:
//   req_i   - request vector
//   last_i  - index of the previous winner
//   win_o   - one-hot winner (all zero when no request)
//   valid_o - at least one request present
module rr_priority_picker #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     win_o,
    output logic             valid_o
);

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        // k walks the priority order: last+1, last+2, ... , last (wraps to itself last).
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid_o && (j == ((int'(last_i) + k) % N)) && req_i[j]) begin
                    win_o[j] = 1'b1;
                    valid_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rect_draw_arbiter.sv
// rtl/rect_draw_arbiter.sv - round-robin arbiter scanning filled rectangles onto the VGA port
// Purpose: picks one requester, latches its rectangle, plots it row-major one pixel per
// clock, then pulses that requester's done.
// Ports:
//   clk, reset                          - clock, synchronous active-high reset
//   req                                 - per-requester level request
//   req_x/req_y/req_w/req_h/req_colour  - packed per-requester descriptors
//   grant, done                         - one-hot current owner, one-cycle completion pulse
//   vga_x/vga_y/vga_colour/vga_plot     - registered VGA adapter write port
// Optional feature: define RECT_DRAW_ARBITER_CLIP_EN to suppress plotting off-screen pixels.
module rect_draw_arbiter
    import rect_draw_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [X_W*NUM_REQ-1:0]     req_x,
    input  logic [Y_W*NUM_REQ-1:0]     req_y,
    input  logic [SZ_W*NUM_REQ-1:0]    req_w,
    input  logic [SZ_W*NUM_REQ-1:0]    req_h,
    input  logic [COL_W*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [COL_W-1:0]           vga_colour,
    output logic                       vga_plot
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (SCREEN_W > (1 << X_W) || SCREEN_H > (1 << Y_W)) begin : g_bad_screen
        $error("rect_draw_arbiter: screen size exceeds coordinate width");
    end

    // Unpacked views of the packed descriptor buses.
    logic [X_W-1:0]   rx [NUM_REQ];
    logic [Y_W-1:0]   ry [NUM_REQ];
    logic [SZ_W-1:0]  rw [NUM_REQ];
    logic [SZ_W-1:0]  rh [NUM_REQ];
    logic [COL_W-1:0] rc [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign rx[i] = req_x[i*X_W +: X_W];
        assign ry[i] = req_y[i*Y_W +: Y_W];
        assign rw[i] = req_w[i*SZ_W +: SZ_W];
        assign rh[i] = req_h[i*SZ_W +: SZ_W];
        assign rc[i] = req_colour[i*COL_W +: COL_W];
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [X_W-1:0]     bx_q, bx_d;
    logic [Y_W-1:0]     by_q, by_d;
    logic [SZ_W-1:0]    bw_q, bw_d, bh_q, bh_d;
    logic [COL_W-1:0]   bc_q, bc_d;
    logic [SZ_W-1:0]    col_q, col_d, row_q, row_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic [X_W-1:0]     vx_q, vx_d;
    logic [Y_W-1:0]     vy_q, vy_d;
    logic [COL_W-1:0]   vc_q, vc_d;
    logic               plot_q, plot_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i   (req),
        .last_i  (last_q),
        .win_o   (pick_oh),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_idx = IDX_W'(i);
        end
    end

    // Pixel selected for the next cycle's output registers.
    logic               pix_en;
    logic [X_W-1:0]     pix_bx;
    logic [Y_W-1:0]     pix_by;
    logic [SZ_W-1:0]    pix_c, pix_r;
`ifdef RECT_DRAW_ARBITER_CLIP_EN
    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);
    logic [X_W:0]       x_sum;
    logic [Y_W:0]       y_sum;
`else
    logic [X_W-1:0]     x_sum;
    logic [Y_W-1:0]     y_sum;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bw_d    = bw_q;
        bh_d    = bh_q;
        bc_d    = bc_q;
        col_d   = col_q;
        row_d   = row_q;
        grant_d = grant_q;
        done_d  = '0;
        vc_d    = vc_q;
        pix_en  = 1'b0;
        pix_bx  = bx_q;
        pix_by  = by_q;
        pix_c   = col_q;
        pix_r   = row_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d = DRAW;
                    last_d  = pick_idx;
                    bx_d    = rx[pick_idx];
                    by_d    = ry[pick_idx];
                    bw_d    = rw[pick_idx];
                    bh_d    = rh[pick_idx];
                    bc_d    = rc[pick_idx];
                    col_d   = '0;
                    row_d   = '0;
                    grant_d = pick_oh;
                    vc_d    = rc[pick_idx];
                    // First pixel comes straight from the inputs so it appears next cycle.
                    pix_en  = 1'b1;
                    pix_bx  = rx[pick_idx];
                    pix_by  = ry[pick_idx];
                    pix_c   = '0;
                    pix_r   = '0;
                end
            end
            DRAW: begin
                // col_q/row_q name the pixel currently on the port.
                if (col_q == bw_q && row_q == bh_q) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end else begin
                    if (col_q == bw_q) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    pix_en = 1'b1;
                    pix_c  = col_d;
                    pix_r  = row_d;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

`ifdef RECT_DRAW_ARBITER_CLIP_EN
        x_sum  = {1'b0, pix_bx} + (X_W+1)'(pix_c);
        y_sum  = {1'b0, pix_by} + (Y_W+1)'(pix_r);
        plot_d = pix_en && (x_sum < X_LIM) && (y_sum < Y_LIM);
`else
        x_sum  = pix_bx + X_W'(pix_c);
        y_sum  = pix_by + Y_W'(pix_r);
        plot_d = pix_en;
`endif
        vx_d = pix_en ? x_sum[X_W-1:0] : vx_q;
        vy_d = pix_en ? y_sum[Y_W-1:0] : vy_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);  // so requester 0 is searched first
            bx_q    <= '0;
            by_q    <= '0;
            bw_q    <= '0;
            bh_q    <= '0;
            bc_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bw_q    <= bw_d;
            bh_q    <= bh_d;
            bc_q    <= bc_d;
            col_q   <= col_d;
            row_q   <= row_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            plot_q  <= plot_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;
    assign vga_plot   = plot_q;

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// tb/tb_rect_draw_arbiter.sv - self-checking bench for rect_draw_arbiter
module tb_rect_draw_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [11:0] req_w;
    logic [11:0] req_h;
    logic [8:0]  req_colour;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    logic [7:0] bx [3];
    logic [6:0] by [3];
    logic [3:0] bw [3];
    logic [3:0] bh [3];
    logic [2:0] bc [3];

    assign req_x      = {bx[2], bx[1], bx[0]};
    assign req_y      = {by[2], by[1], by[0]};
    assign req_w      = {bw[2], bw[1], bw[0]};
    assign req_h      = {bh[2], bh[1], bh[0]};
    assign req_colour = {bc[2], bc[1], bc[0]};

    rect_draw_arbiter #(
        .NUM_REQ  (3),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int idx; int x; int y; int w; int h; int c;
        int npix; int lx; int ly;
    } vec_t;

    // Request one rectangle from an IDLE cycle and check every pixel, done and return to IDLE.
    // drop_at >= 0: after that pixel, drop req and scribble on the descriptor.
    task automatic run_rect(input vec_t v, input int drop_at);
        int col, row, ex, ey, ep;
        bx[v.idx] = 8'(v.x);
        by[v.idx] = 7'(v.y);
        bw[v.idx] = 4'(v.w);
        bh[v.idx] = 4'(v.h);
        bc[v.idx] = 3'(v.c);
        req[v.idx] = 1'b1;
        for (int p = 0; p < v.npix; p++) begin
            tick();
            col = p % (v.w + 1);
            row = p / (v.w + 1);
            ex  = (v.x + col) & 255;
            ey  = (v.y + row) & 127;
            ep  = 1;
`ifdef RECT_DRAW_ARBITER_CLIP_EN
            if (v.x + col >= 160 || v.y + row >= 120) ep = 0;
`endif
            chk("pixel", {10'd0, vga_plot, grant, vga_colour, vga_y, vga_x},
                {10'd0, ep[0], 3'(1 << v.idx), 3'(v.c), 7'(ey), 8'(ex)});
            if (p == v.npix - 1)
                chk("last_xy", {17'd0, vga_y, vga_x}, {17'd0, 7'(v.ly), 8'(v.lx)});
            if (p == drop_at) begin
                req[v.idx] = 1'b0;
                bx[v.idx]  = 8'(v.x + 77);
                by[v.idx]  = 7'(v.y + 9);
                bc[v.idx]  = ~bc[v.idx];
            end
        end
        tick();
        chk("done", {25'd0, done, grant, vga_plot}, {25'd0, 3'(1 << v.idx), 3'(1 << v.idx), 1'b0});
        req[v.idx] = 1'b0;
        tick();
        chk("idle", {25'd0, done, grant, vga_plot}, 32'd0);
    endtask

    vec_t vecs [5];
    vec_t vb;

    initial begin
        int order [4];
        req = '0;
        for (int i = 0; i < 3; i++) begin
            bx[i] = '0; by[i] = '0; bw[i] = '0; bh[i] = '0; bc[i] = '0;
        end
        //          idx  x    y    w   h   c  npix  lx   ly
        vecs[0] = '{0,   10,  20,  1,  1,  4,  4,   11,  21};
        vecs[1] = '{2,   0,   0,   0,  0,  7,  1,   0,   0};
        vecs[2] = '{1,   100, 50,  15, 0,  2,  16,  115, 50};
        vecs[3] = '{0,   158, 119, 3,  1,  5,  8,   161, 120};
        vecs[4] = '{2,   250, 126, 7,  2,  1,  24,  1,   0};

        reset = 1'b1;
        repeat (2) tick();
        chk("reset_state", {14'd0, grant, done, vga_plot, vga_colour, vga_y, vga_x}, 32'd0);
        reset = 1'b0;
        tick();
        chk("reset_idle", {25'd0, grant, done, vga_plot}, 32'd0);

        for (int t = 0; t < 5; t++) run_rect(vecs[t], -1);

        // All three requesting, 1x1 rectangles: last winner was 2, so order is 0,1,2,0.
        order = '{0, 1, 2, 0};
        for (int i = 0; i < 3; i++) begin
            bx[i] = 8'(10 * i); by[i] = 7'(i); bw[i] = '0; bh[i] = '0; bc[i] = 3'(i + 1);
        end
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", {20'd0, grant, vga_plot, vga_x},
                {20'd0, 3'(1 << order[k]), 1'b1, 8'(10 * order[k])});
            tick();
            chk("rr_done", {26'd0, done, grant}, {26'd0, 3'(1 << order[k]), 3'(1 << order[k])});
            tick();
            chk("rr_idle", {28'd0, grant, vga_plot}, 32'd0);
            if (k == 3) req = 3'b000;
        end
        tick();
        chk("rr_stays_idle", {28'd0, grant, vga_plot}, 32'd0);

        // Drop request and change descriptor mid-draw: original rectangle still completes.
        vb = '{1, 30, 40, 3, 3, 6, 16, 33, 43};
        run_rect(vb, 4);

        // Reset during pixel 5 of a 4x4 rectangle from requester 0.
        bx[0] = 8'd5; by[0] = 7'd5; bw[0] = 4'd3; bh[0] = 4'd3; bc[0] = 3'd6;
        req = 3'b001;
        for (int p = 0; p < 5; p++) tick();
        chk("abort_pre", {20'd0, grant, vga_plot, vga_x}, {20'd0, 3'b001, 1'b1, 8'd5});
        reset = 1'b1;
        req   = 3'b000;
        tick();
        chk("abort", {25'd0, vga_plot, grant, done}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort_no_done", {25'd0, done, grant, vga_plot}, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            bw[i] = '0; bh[i] = '0;
        end
        req = 3'b111;
        tick();
        chk("post_reset_rr", {29'd0, grant}, 32'b001);
        tick();
        chk("post_reset_done", {29'd0, done}, 32'b001);
        req = 3'b000;
        tick();
        chk("post_reset_idle", {28'd0, grant, vga_plot}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
